piso_tx_scheduler: RTL and testbench
====================================

PISO_TX_SCHEDULER -- requirements
Module: piso_tx_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the word width in bits (legal range ≥ 2).
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (legal range ≥ 2).
REQ-003 The block SHALL define IDW = $clog2(NUM_REQ) as a derived width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits: bit i means requester i offers a word.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i's word is at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 The block SHALL have port tx_pause, input, 1 bit: freezes serialization while high.
REQ-010 The block SHALL have port dout, output, 1 bit: serial data, LSB first.
REQ-011 The block SHALL have port dout_valid, output, 1 bit: dout carries a live bit this cycle.
REQ-012 The block SHALL have ports dout_first and dout_last, output, 1 bit each: mark bit 0 and bit DATA_WIDTH-1 of a word.
REQ-013 The block SHALL have port dout_src, output, IDW bits: index of the requester whose word is on dout.
REQ-014 The block SHALL have port busy, output, 1 bit: high while the FSM is in SHIFT.

Function
REQ-015 The block SHALL have FSM states IDLE and SHIFT, an internal DATA_WIDTH-bit shift register, a bit counter of $clog2(DATA_WIDTH) bits, and a round-robin pointer rr_ptr of IDW bits.
REQ-016 The arbiter SHALL grant when the state is IDLE, or when the state is SHIFT with the counter at DATA_WIDTH-1 and tx_pause low. It SHALL select the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
REQ-017 req_ready SHALL be combinational, at most one bit high, and zero whenever no grant opportunity exists or tx_pause=1.
REQ-018 On a transfer from requester i at edge t: shift reg <= word i, counter <= 0, state <= SHIFT, dout_src <= i, rr_ptr <= (i+1) mod NUM_REQ.
REQ-019 In SHIFT with tx_pause=0: dout = shift_reg[0], and dout_valid = 1. dout_first = 1 when the counter is 0. dout_last = 1 when the counter is DATA_WIDTH-1. At the edge, shift reg shifts right with zero fill and the counter increments.
REQ-020 Latency SHALL be as follows: the bit 0 of a word accepted at edge t appears in the cycle after t, and its bit k appears k cycles later, absent pauses.
REQ-021 If there is no transfer when the last bit completes, the state SHALL return to IDLE. If there is a transfer, the next word's bit 0 SHALL follow with zero gap cycles.
REQ-022 In SHIFT with tx_pause=1: dout_valid, dout_first and dout_last SHALL be 0, and the shift reg, counter, dout_src and state SHALL hold.
REQ-023 In IDLE: dout_valid, dout_first, dout_last, dout and busy SHALL be 0. tx_pause SHALL suppress grants in IDLE too.
REQ-024 The block SHALL sample req_data only at the transfer edge; later changes SHALL NOT affect the word in flight.
REQ-025 A requester that drops req_valid before it is granted SHALL lose nothing and SHALL NOT affect rr_ptr.

Reset
REQ-026 When resetn=0 at an edge: state = IDLE, shift reg = 0, counter = 0, rr_ptr = 0, dout_src = 0.
REQ-027 Consequently, after reset all outputs SHALL be 0, and req_ready SHALL follow REQ-016 from the first cycle with resetn=1.
REQ-028 Reset asserted mid-word SHALL abort the word with no further dout_valid. The aborted word SHALL NOT be retransmitted.

Verification
REQ-029 Single word: req_valid=4'b0001 with word 0xA5C3 for one transfer. Required response: dout over 16 cycles = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, with dout_first on cycle 1, dout_last on cycle 16, dout_src=0, then IDLE.
REQ-030 Round-robin: all four req_valid high continuously. Required response: grant order 0,1,2,3,0, with back-to-back words, no gap cycles, and dout_valid high continuously for 80 cycles.
REQ-031 Pointer skip: after requester 1 is served, only req_valid[0] and req_valid[3] are high. Required response: requester 3 is granted before requester 0.
REQ-032 Pause: tx_pause=1 for 3 cycles at bit 5 of 0xFFFF. Required response: dout_valid is low for 3 cycles, the word is still 16 valid bits, dout_last arrives 3 cycles later than unpaused, and req_ready stays low while paused.
REQ-033 Reset mid-word: resetn=0 at bit 7. Required response: the next cycle has all outputs 0 and rr_ptr=0. A fresh request from requester 2 after reset is sent complete, with dout_src=2.
REQ-034 Data stability: req_data changes on the cycle after the transfer. Required response: the serialized bits match the value captured at the transfer edge.

Source files
------------

// File: rtl/piso_tx_scheduler.sv
// rtl/piso_tx_scheduler.sv - round-robin arbiter feeding an LSB-first parallel-to-serial transmitter
module piso_tx_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             tx_pause,
    output logic                             dout,
    output logic                             dout_valid,
    output logic                             dout_first,
    output logic                             dout_last,
    output logic [$clog2(NUM_REQ)-1:0]       dout_src,
    output logic                             busy
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(DATA_WIDTH);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CW-1:0]         r_cnt;
    logic [IDW-1:0]        r_rr_ptr;
    logic [IDW-1:0]        r_src;

    logic                  w_cnt_last;
    logic                  w_live;
    logic                  w_grant_opp;
    logic                  w_found;
    logic                  w_xfer;
    logic [IDW-1:0]        w_sel;
    logic [IDW-1:0]        w_sel_inc;

    function automatic logic [IDW-1:0] wrap_idx(input int v);
        return IDW'(v % NUM_REQ);
    endfunction

    assign w_cnt_last  = (r_cnt == CW'(DATA_WIDTH - 1));
    assign w_live      = (r_state == ST_SHIFT) && !tx_pause;
    // A new word may be taken only when the serializer is empty or finishing its last bit.
    assign w_grant_opp = !tx_pause && ((r_state == ST_IDLE) || w_cnt_last);
    assign w_xfer      = w_grant_opp && w_found;
    assign w_sel_inc   = (w_sel == IDW'(NUM_REQ - 1)) ? '0 : w_sel + IDW'(1);

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[wrap_idx(int'(r_rr_ptr) + k)]) begin
                w_found = 1'b1;
                w_sel   = wrap_idx(int'(r_rr_ptr) + k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_xfer) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_live && w_cnt_last && !w_xfer) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
            r_src    <= '0;
        end else if (w_xfer) begin
            r_shreg  <= req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
            r_cnt    <= '0;
            r_src    <= w_sel;
            r_rr_ptr <= w_sel_inc;
        end else if (w_live) begin
            r_shreg <= r_shreg >> 1;
            r_cnt   <= w_cnt_last ? '0 : r_cnt + CW'(1);
        end
    end

    assign dout       = w_live && r_shreg[0];
    assign dout_valid = w_live;
    assign dout_first = w_live && (r_cnt == '0);
    assign dout_last  = w_live && w_cnt_last;
    assign dout_src   = r_src;
    assign busy       = (r_state == ST_SHIFT);
endmodule

// File: tb/tb_piso_tx_scheduler.sv
// tb/tb_piso_tx_scheduler.sv - directed and randomized checks of piso_tx_scheduler against a word-level model
module tb_piso_tx_scheduler;
    localparam int DW  = 16;
    localparam int NR  = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             tx_pause = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]    req_ready;
    logic             dout, dout_valid, dout_first, dout_last, busy;
    logic [IDW-1:0]   dout_src;

    always #5 clk = ~clk;

    piso_tx_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_pause   (tx_pause),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_first (dout_first),
        .dout_last  (dout_last),
        .dout_src   (dout_src),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: which word is on the wire, which bit of it, who sent it, whose turn is next.
    bit          m_active = 0;
    logic [DW-1:0] m_word = '0;
    int          m_pos = 0;
    int          m_src = 0;
    int          m_ptr = 0;

    int            cyc = 0;
    int            s_grant;
    logic [NR-1:0] s_ready;
    bit            s_dv;
    logic [DW-1:0] col_word;
    int            col_n;
    int            t_first, t_last;

    task automatic cycle();
        int  g;
        int  idx;
        bit  live, opp;
        logic [NR-1:0] e_ready;
        #2;
        live = m_active && !tx_pause;
        opp  = !tx_pause && (!m_active || m_pos == DW - 1);
        g = -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        e_ready = '0;
        if (opp && g >= 0) e_ready[g] = 1'b1;
        check_eq("req_ready", req_ready, e_ready);
        check_eq("dout_valid", dout_valid, live);
        check_eq("dout", dout, live ? m_word[m_pos] : 1'b0);
        check_eq("dout_first", dout_first, live && m_pos == 0);
        check_eq("dout_last", dout_last, live && m_pos == DW - 1);
        check_eq("busy", busy, m_active);
        check_eq("dout_src", dout_src, m_src);
        s_ready = req_ready;
        s_dv    = dout_valid;
        s_grant = -1;
        for (int i = 0; i < NR; i++) if (req_ready[i] && req_valid[i]) s_grant = i;
        if (dout_valid) begin
            if (col_n < DW) col_word[col_n] = dout;
            col_n++;
        end
        if (dout_first) t_first = cyc;
        if (dout_last)  t_last  = cyc;
        @(posedge clk);
        if (!resetn) begin
            m_active = 0; m_word = '0; m_pos = 0; m_src = 0; m_ptr = 0;
        end else if (opp && g >= 0) begin
            m_active = 1; m_word = req_data[g*DW +: DW]; m_pos = 0; m_src = g; m_ptr = (g + 1) % NR;
        end else if (live) begin
            if (m_pos == DW - 1) m_active = 0;
            else m_pos++;
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && m_active; i++) cycle();
        check_eq("drain_idle", busy, 1'b0);
    endtask

    task automatic col_clear();
        col_n = 0; col_word = '0; t_first = -1; t_last = -1;
    endtask

    initial begin
        int c0, ng, n_v, first_v, last_v, k;
        int order[5];
        logic [DW-1:0] w;

        col_clear();
        @(posedge clk); #1;
        cycle();
        resetn = 1'b1;

        // single word 0xA5C3
        req_data[0 +: DW] = 16'hA5C3; req_valid = 4'b0001; col_clear(); c0 = cyc;
        cycle();
        check_eq("s1_grant", s_grant, 0);
        req_valid = '0;
        repeat (17) cycle();
        check_eq("s1_bits", col_n, DW);
        check_eq("s1_word", col_word, 16'hA5C3);
        check_eq("s1_first_lat", t_first - c0, 1);
        check_eq("s1_last_lat", t_last - c0, 16);

        // round-robin from reset, back-to-back
        resetn = 1'b0; cycle(); resetn = 1'b1;
        req_data = {$urandom, $urandom}; req_valid = '1;
        ng = 0; n_v = 0; first_v = -1; last_v = -1;
        for (int i = 0; i < 200 && (ng < 5 || m_active); i++) begin
            cycle();
            if (s_dv) begin
                n_v++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (s_grant >= 0) begin
                if (ng < 5) order[ng] = s_grant;
                ng++;
                if (ng == 5) req_valid = '0;
            end
        end
        for (k = 0; k < 5; k++) check_eq($sformatf("rr_order%0d", k), order[k], k % NR);
        check_eq("rr_valid_cnt", n_v, 80);
        check_eq("rr_span", last_v - first_v + 1, 80);
        drain();

        // pointer skip: serve 1, then only 0 and 3 request
        req_valid = 4'b0010; cycle();
        check_eq("skip_g1", s_grant, 1);
        req_valid = 4'b1001; ng = 0;
        for (int i = 0; i < 100 && ng < 2; i++) begin
            cycle();
            if (s_grant >= 0) begin
                order[ng] = s_grant; ng++;
                if (ng == 2) req_valid = '0;
            end
        end
        check_eq("skip_first", order[0], 3);
        check_eq("skip_second", order[1], 0);
        drain();

        // pause for 3 cycles at bit 5 of 0xFFFF
        req_data[0 +: DW] = 16'hFFFF; req_valid = 4'b0001; col_clear(); c0 = cyc;
        cycle();
        req_valid = '0;
        for (int i = 0; i < 50 && col_n < 5; i++) cycle();
        tx_pause = 1'b1; req_valid = '1;
        repeat (3) begin
            cycle();
            check_eq("pause_ready", s_ready, '0);
            check_eq("pause_dv", s_dv, 1'b0);
        end
        tx_pause = 1'b0; req_valid = '0;
        drain();
        check_eq("pause_bits", col_n, DW);
        check_eq("pause_word", col_word, 16'hFFFF);
        check_eq("pause_last_lat", t_last - c0, 19);

        // reset at bit 7, then requester 2
        req_data = {$urandom, $urandom}; req_valid = 4'b0001; col_clear();
        cycle();
        req_valid = '0;
        for (int i = 0; i < 50 && col_n < 7; i++) cycle();
        resetn = 1'b0; cycle(); resetn = 1'b1;
        check_eq("rst_dv", dout_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_src", dout_src, 0);
        req_valid = 4'b0100; w = req_data[2*DW +: DW]; col_clear();
        cycle();
        check_eq("rst_ready", s_ready, 4'b0100);
        check_eq("rst_src2", dout_src, 2);
        req_valid = '0;
        drain();
        check_eq("rst_bits", col_n, DW);
        check_eq("rst_word", col_word, w);

        // data changes right after the transfer edge
        w = DW'($urandom); req_data[0 +: DW] = w; req_valid = 4'b0001; col_clear();
        cycle();
        req_data[0 +: DW] = ~w; req_valid = '0;
        drain();
        check_eq("stab_word", col_word, w);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req_valid = NR'($urandom);
            req_data  = {$urandom, $urandom};
            tx_pause  = ($urandom_range(7) == 0);
            resetn    = ($urandom_range(99) != 0);
            cycle();
        end
        resetn = 1'b1; tx_pause = 1'b0; req_valid = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
